dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Data memory controller: byte-addressable 32-bit RAM with configurable wait states,
// lane-aware writes, sign/zero-extended reads, a memory-mapped output register and a sticky fault flag.
module dmem_ctrl #(
  parameter int                DEPTH       = 1024,
  parameter int                ADDR_W      = 32,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE     = 32'h0000_4000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       ddata_w,
  output logic [31:0]       ddata_r,
  output logic              READY,
  output logic              STALL,
  output logic              ERR,
  output logic [31:0]       io_out
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              uns_reg, rd_reg, wr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;
  logic [31:0]       io_reg;
  logic              out_zero_reg, out_io_reg, out_uns_reg;
  logic [1:0]        out_lane_reg, out_size_reg;

  logic              req, accept, go_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_size, lane;
  logic              cur_uns, cur_rd, cur_wr;
  logic [31:0]       cur_wdata;
  logic [IW-1:0]     idx;
  logic              io_hit, oor, fault, mem_we;
  logic [3:0]        be;
  logic [31:0]       wlane, raw_word, src_word, shifted;

  assign req = MemRead | MemWrite;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT:    if (cnt_reg == LAST_WAIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept  = (state_reg == IDLE) && req;
  assign go_done = (state_next == DONE) && (state_reg != DONE);

  // With zero wait states the completing edge is also the accepting edge, so use the live inputs there.
  assign cur_addr  = (state_reg == IDLE) ? daddr    : addr_reg;
  assign cur_size  = (state_reg == IDLE) ? size     : size_reg;
  assign cur_uns   = (state_reg == IDLE) ? uns      : uns_reg;
  assign cur_rd    = (state_reg == IDLE) ? MemRead  : rd_reg;
  assign cur_wr    = (state_reg == IDLE) ? MemWrite : wr_reg;
  assign cur_wdata = (state_reg == IDLE) ? ddata_w  : wdata_reg;

  assign lane   = cur_addr[1:0];
  assign idx    = cur_addr[IW+1:2];
  assign io_hit = (cur_addr == IO_BASE) && (cur_size == 2'b10);
  assign oor    = |cur_addr[ADDR_W-1:IW+2];
  // A non-word access at IO_BASE beyond the array would alias a RAM word, so it faults too.
  assign fault  = (cur_size == 2'b11) || ((cur_size == 2'b01) && lane[0]) ||
                  ((cur_size == 2'b10) && (lane != 2'b00)) || (cur_rd && cur_wr) ||
                  (oor && !io_hit);
  assign mem_we = go_done && cur_wr && !fault && !io_hit && !RESET;

  always_comb begin
    be    = 4'b0000;
    wlane = cur_wdata;
    case (cur_size)
      2'b00: begin be = 4'b0001 << lane; wlane = {4{cur_wdata[7:0]}}; end
      2'b01: begin be = lane[1] ? 4'b1100 : 4'b0011; wlane = {2{cur_wdata[15:0]}}; end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_lane_reg;
      always_ff @(posedge CLK) begin
        if (mem_we && be[gi]) lane_mem[idx] <= wlane[gi*8 +: 8];
        if (go_done) rd_lane_reg <= lane_mem[idx];
      end
      assign raw_word[gi*8 +: 8] = rd_lane_reg;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      size_reg     <= 2'b00;
      uns_reg      <= 1'b0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      wdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
      io_reg       <= 32'd0;
      out_zero_reg <= 1'b1;
      out_io_reg   <= 1'b0;
      out_lane_reg <= 2'b00;
      out_size_reg <= 2'b10;
      out_uns_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_reg == WAIT && state_next == WAIT) ? cnt_reg + 4'd1 : 4'd0;
      if (accept) begin
        addr_reg  <= daddr;
        size_reg  <= size;
        uns_reg   <= uns;
        rd_reg    <= MemRead;
        wr_reg    <= MemWrite;
        wdata_reg <= ddata_w;
      end
      if (go_done) begin
        out_zero_reg <= fault;
        out_io_reg   <= io_hit;
        out_lane_reg <= lane;
        out_size_reg <= cur_size;
        out_uns_reg  <= cur_uns;
        if (fault) err_reg <= 1'b1;
        if (cur_wr && !fault && io_hit) io_reg <= cur_wdata;
      end
    end
  end

  assign src_word = out_io_reg ? io_reg : raw_word;
  assign shifted  = src_word >> {out_lane_reg, 3'b000};

  always_comb begin
    ddata_r = shifted;
    case (out_size_reg)
      2'b00: ddata_r = {{24{~out_uns_reg & shifted[7]}}, shifted[7:0]};
      2'b01: ddata_r = {{16{~out_uns_reg & shifted[15]}}, shifted[15:0]};
      default: ddata_r = shifted;
    endcase
    if (out_zero_reg) ddata_r = 32'd0;
  end

  assign READY  = (state_reg == DONE);
  assign STALL  = req && !READY && !RESET;
  assign ERR    = err_reg;
  assign io_out = io_reg;

endmodule
